upsample: RTL
=============

// Module: upsample
// PURPOSE
//  Interpolating rate expander. It is the counterpart of the audio-path decimator.
//  It accepts samples at Fs/Nfreq, strobed by endatain, and emits samples at Fs = 48 kHz, strobed by enfs.
//  Missing output slots are filled by zero-insertion or sample-and-hold, selected by holdmode.
//  It sits between the low-rate processing stage and the 48 kHz DAC/output chain.
// PARAMETERS
//  DATA_W   18  sample width, two's complement
//  NFREQ_W  4   width of the rate factor
// PORTS
//  clock      in   1       master clock
//  reset      in   1       synchronous reset, active high
//  Nfreq      in   NFREQ_W interpolation factor; 0 is treated as 1
//  holdmode   in   1       0 = zero-insert, 1 = sample-and-hold
//  datain     in   DATA_W  low-rate input sample
//  endatain   in   1       input sample valid, single-cycle pulse, rate Fs/Nfreq
//  enfs       in   1       48 kHz output slot strobe, single-cycle pulse
//  dataout    out  DATA_W  high-rate output sample
//  endataout  out  1       output valid, single-cycle pulse, rate Fs
//  overrun    out  1       pulse: endatain arrived while the pending sample was still unconsumed
//  underrun   out  1       pulse: a phase-0 slot occurred with no pending sample
// BEHAVIOUR
//  Reset: all outputs and all internal state clear to 0.
//   - dataout=0, endataout=0, overrun=0, underrun=0.
//   - phase=0, pending_vld=0, pending=0, last=0, nlatch=1.
//  Input capture: on endatain, pending<=datain and pending_vld<=1.
//   - If pending_vld was already 1 and that sample is not consumed in the same cycle:
//     the old sample is overwritten and overrun pulses for 1 cycle.
//  Output slot: on enfs, endataout=1 on the next cycle; latency is 1 clock from enfs.
//   - phase==0 with a sample available:
//     - dataout<=sample, last<=sample, pending_vld<=0.
//     - nlatch<=max(Nfreq,1); phase<=max(Nfreq,1)-1.
//   - phase==0 with no sample available: underrun pulses.
//     - dataout<=holdmode ? last : 0.
//     - phase reloads exactly as above, so the slot grid is not stalled.
//   - phase!=0: dataout<=holdmode ? last : 0; phase<=phase-1.
//  Simultaneous endatain and enfs at phase 0: datain bypasses pending.
//   - datain goes straight to dataout/last; pending_vld ends at 0; no overrun.
//   - If pending_vld was already 1: the old pending sample is dropped and overrun pulses.
//  Simultaneous endatain and enfs at phase!=0: capture proceeds as normal.
//  Nfreq is sampled only at phase-0 reload; mid-period changes take effect at the next reload.
//  Nfreq=1 (or 0): every enfs emits the latest sample; this is pass-through at Fs.
//  Between strobes:
//   - dataout holds its last value.
//   - endataout, overrun and underrun are 0 except for their 1-cycle pulses.
//  No gain compensation is applied; zero-insert output amplitude scales by 1/Nfreq downstream.
//  Reset asserted mid-period: it aborts immediately.
//   - The next phase-0 slot is the first enfs after reset release.
// STRUCTURE
//  Shared audio package holds:
//   - SAMPLE_W=18, NFREQ_W=4, FS_HZ=48000.
//   - typedef sample_t = logic signed [SAMPLE_W-1:0].
//  Sub-module upsample_phase_ctr:
//   - Contains the down-counter, its reload from max(Nfreq,1) and the phase0 flag.
//   - Advances on enfs; reset clears it.
//  Top level holds the pending buffer, the last register, the slot fill mux and the status pulses.
// TESTING
//  Nfreq=4, holdmode=0:
//   - Stimulus: endatain with 100, 200 every 4th enfs, aligned to phase 0.
//   - Response: dataout = 100,0,0,0,200,0,0,0; one endataout per enfs; no status pulses.
//  Nfreq=3, holdmode=1:
//   - Stimulus: inputs -5, 7.
//   - Response: dataout = -5,-5,-5,7,7,7.
//  Nfreq=2, no endatain for 2 periods:
//   - Response: underrun pulses on each phase-0 slot.
//   - dataout=0 in zero-insert mode; dataout=last in hold mode.
//  Two endatain (11, then 22) within one period:
//   - Response: overrun pulses once; the next phase-0 output is 22.
//  Nfreq changed 4->2 at phase 2:
//   - Response: the current period finishes at 4 slots, then 2-slot periods follow.
//   - Also: Nfreq=0 gives pass-through.
//  Reset asserted mid-period with pending_vld=1:
//   - Response: all outputs 0, pending cleared.
//   - The first enfs after reset release is a phase-0 slot and flags underrun.

Source files
------------

// File: rtl/upsample_pkg.sv
// Shared audio-path constants and the sample type used by the rate converters.
package upsample_pkg;

  localparam int SAMPLE_W = 18;
  localparam int NFREQ_W  = 4;
  localparam int FS_HZ    = 48000;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/upsample_phase_ctr.sv
// Output-slot phase counter for the interpolator: counts enfs strobes down
// from max(Nfreq,1)-1 and flags phase 0, where a new low-rate sample is due.
module upsample_phase_ctr
  import upsample_pkg::*;
#(
  parameter int NFREQ_W = upsample_pkg::NFREQ_W
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enfs_i,
  input  logic [NFREQ_W-1:0] nfreq_i,
  output logic               phase0_o
);

  logic [NFREQ_W-1:0] phase_q, phase_d;
  logic [NFREQ_W-1:0] nlatch_q, nlatch_d;

  // A factor of 0 behaves as 1 (pass-through).
  function automatic logic [NFREQ_W-1:0] eff_factor(input logic [NFREQ_W-1:0] n);
    return (n == '0) ? NFREQ_W'(1) : n;
  endfunction

  assign phase0_o = (phase_q == '0);

  // Next phase: Nfreq is only sampled on the phase-0 reload, so a change
  // mid-period lets the current period run to completion.
  always_comb begin
    phase_d  = phase_q;
    nlatch_d = nlatch_q;
    if (enfs_i) begin
      if (phase_q == '0) begin
        nlatch_d = eff_factor(nfreq_i);
        phase_d  = eff_factor(nfreq_i) - NFREQ_W'(1);
      end else begin
        phase_d  = phase_q - NFREQ_W'(1);
      end
    end
  end

  // Counter state; reset makes the next enfs a phase-0 slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q  <= '0;
      nlatch_q <= NFREQ_W'(1);
    end else begin
      phase_q  <= phase_d;
      nlatch_q <= nlatch_d;
    end
  end

endmodule

// File: rtl/upsample.sv
// Interpolating rate expander: low-rate samples in on endatain, Fs samples
// out on enfs, empty slots filled by zero-insertion or sample-and-hold.
module upsample
  import upsample_pkg::*;
#(
  parameter int DATA_W  = SAMPLE_W,
  parameter int NFREQ_W = upsample_pkg::NFREQ_W
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NFREQ_W-1:0]       Nfreq,
  input  logic                     holdmode,
  input  logic signed [DATA_W-1:0] datain,
  input  logic                     endatain,
  input  logic                     enfs,
  output logic signed [DATA_W-1:0] dataout,
  output logic                     endataout,
  output logic                     overrun,
  output logic                     underrun
);

  logic                     phase0;
  logic                     slot0;
  logic                     avail;
  logic signed [DATA_W-1:0] sample;

  logic signed [DATA_W-1:0] pending_q, pending_d;
  logic                     pending_vld_q, pending_vld_d;
  logic signed [DATA_W-1:0] last_q, last_d;
  logic signed [DATA_W-1:0] dout_q, dout_d;
  logic                     eo_q, ovr_q, ovr_d, und_q, und_d;

  // Value for a slot that carries no new sample.
  function automatic logic signed [DATA_W-1:0] fill(input logic hold,
                                                    input logic signed [DATA_W-1:0] held);
    return hold ? held : '0;
  endfunction

  upsample_phase_ctr #(.NFREQ_W(NFREQ_W)) u_phase (
    .clk_i    (clock),
    .rst_i    (reset),
    .enfs_i   (enfs),
    .nfreq_i  (Nfreq),
    .phase0_o (phase0)
  );

  // A fresh input on the phase-0 slot itself bypasses the pending buffer.
  assign slot0  = enfs && phase0;
  assign avail  = endatain || pending_vld_q;
  assign sample = endatain ? datain : pending_q;

  // Slot fill mux, pending buffer management and status pulses.
  always_comb begin
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    last_d        = last_q;
    dout_d        = dout_q;
    // A new input while one is still buffered always loses the old one:
    // either it is overwritten, or it is dropped in favour of the bypass.
    ovr_d         = endatain && pending_vld_q;
    und_d         = slot0 && !avail;

    if (endatain && !slot0) begin
      pending_d     = datain;
      pending_vld_d = 1'b1;
    end

    if (enfs) begin
      if (phase0 && avail) begin
        dout_d        = sample;
        last_d        = sample;
        pending_vld_d = 1'b0;
      end else begin
        dout_d = fill(holdmode, last_q);
      end
    end
  end

  // Registered state and outputs; one clock latency from enfs.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      last_q        <= '0;
      dout_q        <= '0;
      eo_q          <= 1'b0;
      ovr_q         <= 1'b0;
      und_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      last_q        <= last_d;
      dout_q        <= dout_d;
      eo_q          <= enfs;
      ovr_q         <= ovr_d;
      und_q         <= und_d;
    end
  end

  assign dataout   = dout_q;
  assign endataout = eo_q;
  assign overrun   = ovr_q;
  assign underrun  = und_q;

endmodule
